// File: rtl/pc_uart_tx.sv
// pc_uart_tx
// Streams the core program counter and trap flag to a host terminal as
// ASCII text over an 8N1 UART. Each accepted sample becomes an 11-byte
// line: 8 uppercase hex digits of pc (MSB nibble first), a status byte
// ('T' when trap is set, '.' otherwise), then CR and LF.
//
// Ports:
//   clk     - system clock; all state updates on the rising edge
//   reset   - asynchronous, active-high; clears all state, tx idles high
//   sample  - one-cycle strobe qualifying pc/trap
//   pc      - core program counter (32 bits)
//   trap    - core trap flag
//   tx      - registered UART serial output, idle high
//   busy    - high while a frame is in progress
//   dropped - saturating count of samples rejected while busy
//
// Optional build macro: PC_UART_CHANGE_ONLY_EN
//   When defined, a sample arriving in IDLE whose pc/trap match the last
//   frame sent is silently ignored. The first sample after reset is
//   always sent.

module pc_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DROP_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample,
    input  logic [31:0]       pc,
    input  logic              trap,
    output logic              tx,
    output logic              busy,
    output logic [DROP_W-1:0] dropped
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_clk_cnt;
    logic [2:0]        r_bit_idx;
    logic [3:0]        r_byte_idx;
    logic [31:0]       r_cap_pc;
    logic              r_cap_trap;
    logic              r_tx;
    logic [DROP_W-1:0] r_dropped;

    logic [3:0]        w_nibble;
    logic [7:0]        w_byte;
    logic              w_bit_end;
    logic              w_accept;

`ifdef PC_UART_CHANGE_ONLY_EN
    logic [31:0]       r_last_pc;
    logic              r_last_trap;
    logic              r_last_valid;
    logic              w_repeat;

    assign w_repeat = r_last_valid && (pc == r_last_pc) && (trap == r_last_trap);
    assign w_accept = sample && (r_state == S_IDLE) && !w_repeat;
`else
    assign w_accept = sample && (r_state == S_IDLE);
`endif

    assign w_bit_end = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Byte 0..7 are hex digits, index 0 taking pc[31:28].
    always_comb begin
        w_nibble = '0;
        w_byte   = 8'h0A;
        if (r_byte_idx < 4'd8) begin
            w_nibble = 4'(r_cap_pc >> (5'd28 - {r_byte_idx[2:0], 2'b00}));
            w_byte   = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble})
                                          : (8'h37 + {4'h0, w_nibble});
        end else if (r_byte_idx == 4'd8) begin
            w_byte = r_cap_trap ? 8'h54 : 8'h2E;
        end else if (r_byte_idx == 4'd9) begin
            w_byte = 8'h0D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_cap_pc   <= '0;
            r_cap_trap <= 1'b0;
            r_tx       <= 1'b1;
            r_dropped  <= '0;
`ifdef PC_UART_CHANGE_ONLY_EN
            r_last_pc    <= '0;
            r_last_trap  <= 1'b0;
            r_last_valid <= 1'b0;
`endif
        end else begin
            // Any strobe outside IDLE is rejected, including the last stop cycle.
            if (sample && (r_state != S_IDLE) && (r_dropped != '1))
                r_dropped <= r_dropped + DROP_W'(1);

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cap_pc   <= pc;
                        r_cap_trap <= trap;
                        r_clk_cnt  <= '0;
                        r_byte_idx <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= S_START;
`ifdef PC_UART_CHANGE_ONLY_EN
                        r_last_pc    <= pc;
                        r_last_trap  <= trap;
                        r_last_valid <= 1'b1;
`endif
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= w_byte[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= w_byte[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_byte_idx == 4'd10) begin
                            r_byte_idx <= '0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 4'd1;
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx      = r_tx;
    assign busy    = (r_state != S_IDLE);
    assign dropped = r_dropped;

endmodule

// File: tb/tb_pc_uart_tx.sv
// Directed bench for pc_uart_tx with CLKS_PER_BIT=4 and DROP_W=2.
// A small UART receiver samples tx mid-bit on falling clock edges and
// rebuilds each 11-byte line, which is compared to hand-written ASCII.

module tb_pc_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample;
    logic [31:0]   pc;
    logic          trap;
    logic          tx;
    logic          busy;
    logic [DW-1:0] dropped;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    pc_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DROP_W      (DW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sample (sample),
        .pc     (pc),
        .trap   (trap),
        .tx     (tx),
        .busy   (busy),
        .dropped(dropped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns at the falling edge after
    // the rising edge that saw the strobe.
    task automatic pulse(input logic [31:0] p, input logic t);
        pc     = p;
        trap   = t;
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, output logic ok);
        int t;
        logic [7:0] d;
        t  = 0;
        ok = 1'b1;
        d  = '0;
        while (tx !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
        end else begin
            repeat (CPB / 2) @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                repeat (CPB) @(negedge clk);
                d[j] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) ok = 1'b0;
        end
        b = d;
    endtask

    task automatic recv_frame(output logic [87:0] f, output logic ok);
        logic [7:0] b;
        logic       bok;
        f  = '0;
        ok = 1'b1;
        for (int k = 0; k < 11; k++) begin
            recv_byte(b, bok);
            f = {f[79:0], b};
            if (!bok) begin
                ok = 1'b0;
                break;
            end
        end
        if (!ok) f = 'x;
    endtask

    task automatic wait_idle(output int c);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        c = cyc;
    endtask

    logic [87:0] f;
    logic        ok;
    int          a;
    int          c;
    int          bad;

    initial begin
        reset  = 1'b1;
        sample = 1'b0;
        pc     = '0;
        trap   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset held", {84'h0, tx, busy, dropped}, 88'b1000);
        reset = 1'b0;
        @(negedge clk);
        chk("after release", {84'h0, tx, busy, dropped}, 88'b1000);

        // Basic frame and its timing.
        pulse(32'h0000_1A3C, 1'b0);
        a = cyc;
        chk("start bit next cycle", {86'h0, tx, busy}, 88'b01);
        recv_frame(f, ok);
        chk("frame 00001A3C.", f, 88'h30303030_31413343_2E0D0A);
        wait_idle(c);
        chk("busy length", 88'(c - a), 88'd440);
        chk("idle after frame", {86'h0, tx, busy}, 88'b10);

        // Trap status, then a back-to-back frame one cycle after busy falls.
        pulse(32'hDEAD_BEEF, 1'b1);
        recv_frame(f, ok);
        chk("frame DEADBEEFT", f, 88'h44454144_42454546_540D0A);
        wait_idle(c);
        chk("idle-high gap", {86'h0, tx, busy}, 88'b10);
        pulse(32'h89AB_CDEF, 1'b1);
        chk("b2b start bit", {86'h0, tx, busy}, 88'b01);
        recv_frame(f, ok);
        chk("frame 89ABCDEFT", f, 88'h38394142_43444546_540D0A);
        wait_idle(c);
        chk("b2b dropped", {86'h0, dropped}, 88'd0);

        // Five strobes during a frame saturate the 2-bit drop counter.
        pulse(32'hCAFE_0001, 1'b0);
        fork
            recv_frame(f, ok);
            begin
                repeat (5) begin
                    repeat (19) @(negedge clk);
                    pulse($urandom, 1'b1);
                end
            end
        join
        chk("frame CAFE0001.", f, 88'h43414645_30303031_2E0D0A);
        chk("dropped saturated", {86'h0, dropped}, 88'd3);
        wait_idle(c);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("no extra frame", 88'(bad), 88'd0);

        // Reset during byte 4 data bits.
        pulse(32'h1234_5678, 1'b0);
        repeat (175) @(negedge clk);
        #1 reset = 1'b1;
        #1 chk("async reset mid-frame", {84'h0, tx, busy, dropped}, 88'b1000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pulse(32'h0000_0004, 1'b0);
        recv_frame(f, ok);
        chk("frame after reset", f, 88'h30303030_30303034_2E0D0A);
        wait_idle(c);

`ifdef PC_UART_CHANGE_ONLY_EN
        // pc 4 was just sent, so repeating it must be ignored.
        pulse(32'h0000_0004, 1'b0);
        chk("repeat 4 ignored", {86'h0, tx, busy}, 88'b10);
        repeat (5) @(negedge clk);
        pulse(32'h0000_0010, 1'b0);
        recv_frame(f, ok);
        chk("frame 00000010.", f, 88'h30303030_30303130_2E0D0A);
        wait_idle(c);
        repeat (5) @(negedge clk);
        pulse(32'h0000_0010, 1'b0);
        chk("repeat 10 ignored", {86'h0, tx, busy}, 88'b10);
        repeat (20) @(negedge clk);
        pulse(32'h0000_0014, 1'b0);
        recv_frame(f, ok);
        chk("frame 00000014.", f, 88'h30303030_30303134_2E0D0A);
        wait_idle(c);
        repeat (5) @(negedge clk);
        pulse(32'h0000_0010, 1'b1);
        recv_frame(f, ok);
        chk("frame 00000010T", f, 88'h30303030_30303130_540D0A);
        wait_idle(c);
        chk("change-only dropped", {86'h0, dropped}, 88'd0);
`else
        // Without the filter an identical sample still starts a frame.
        pulse(32'h0000_0004, 1'b0);
        chk("repeat sample sent", {86'h0, tx, busy}, 88'b01);
        recv_frame(f, ok);
        chk("repeat frame", f, 88'h30303030_30303034_2E0D0A);
        wait_idle(c);
        chk("final dropped", {86'h0, dropped}, 88'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_uart_tx.md
Name: pc_uart_tx

Overview:
- Telemetry stage downstream of the core: consumes the core's program counter and trap flag and streams them as ASCII text over a UART TX pin.
- Gives a full 32-bit PC trace to a host terminal, where the LEDs show only 11 bits.
- Runs on the fast board clock. The core-side sample strobe is a one-cycle pulse generated in the same domain, once per core clock edge.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200 baud); must be >= 2.
- DROP_W, 8, width of the saturating dropped-sample counter.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- sample, input, 1, one-cycle strobe: pc/trap are valid this cycle.
- pc, input, 32, core program counter.
- trap, input, 1, core trap flag.
- tx, output, 1, UART serial out, 8N1, idle high.
- busy, output, 1, high while a frame is in progress (state != IDLE).
- dropped, output, DROP_W, count of samples rejected while busy; saturating.

Behaviour:
- Reset values (asynchronous): tx=1, busy=0, dropped=0, state=IDLE, bit/byte counters=0, last-sent registers=0.
- Frame format: 11 bytes, sent in order.
  - 8 hex digits of pc, MSB nibble first, uppercase ASCII ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46).
  - Status byte: 'T' (0x54) if trap, else '.' (0x2E).
  - CR (0x0D), then LF (0x0A).
- Each byte is sent as: start bit (0), 8 data bits LSB first, stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- Frame duration: 110*CLKS_PER_BIT cycles.
- Acceptance: when sample=1 and state=IDLE on edge N, pc and trap are latched into a capture register on edge N. tx drives the start bit from edge N+1.
- tx is a registered output, with no combinational path from the inputs.
- State machine:
  - IDLE -> START on an accepted sample.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START (next byte) if byte index < 10, else -> IDLE.
  - The byte index increments on leaving STOP.
- Byte selection is combinational from the capture register and the byte index (0-10). Index 0 selects pc[31:28].
- Busy/drop rule: sample=1 while state != IDLE, including the final cycle of the last stop bit, is dropped.
  - Dropped samples increment dropped by 1.
  - dropped saturates at 2^DROP_W-1 and does not wrap.
  - The capture register is unchanged by a dropped sample.
- busy deasserts on the edge that returns to IDLE. A sample in the following cycle is accepted, giving back-to-back frames separated by 1 idle-high cycle.
- pc and trap are ignored when sample=0. Changes to pc mid-frame do not alter the frame in flight.
- Reset asserted mid-frame:
  - tx returns to 1 immediately (asynchronously) and the partial frame is abandoned.
  - After release, the first accepted sample starts a fresh frame at byte 0.

Optional Feature:
- Macro: PC_UART_CHANGE_ONLY_EN.
- When defined:
  - Last-sent pc/trap registers are updated on each accepted frame.
  - A sample in IDLE whose pc and trap equal the last-sent values is silently ignored: no frame, no dropped increment.
  - The first sample after reset is always sent; a valid-last flag is cleared by reset.
  - Samples while busy are still counted in dropped, regardless of their value.
- When undefined: every sample in IDLE starts a frame. The last-sent registers are not instantiated.

Test Plan:
- Basic frame: CLKS_PER_BIT=4, reset, sample with pc=0x0000_1A3C, trap=0.
  - Required: decoded bytes "00001A3C.\r\n" (0x30 0x30 0x30 0x30 0x31 0x41 0x33 0x43 0x2E 0x0D 0x0A).
  - Frame is 440 cycles; busy falls on cycle 441; tx start bit begins the cycle after sample.
- Trap status: pc=0xDEADBEEF, trap=1.
  - Required: "DEADBEEFT\r\n", with status byte 0x54.
- Drop counting, DROP_W=2: during one frame, pulse sample 5 times.
  - Required: dropped=3 (saturated).
  - Frame content equals the first accepted pc; no extra frame starts.
- Back-to-back: sample in the first cycle after busy falls.
  - Required: second start bit after exactly 1 idle-high cycle; dropped unchanged.
- Reset mid-frame: assert reset during byte 4's data bits.
  - Required: tx=1, busy=0, dropped=0 in the same cycle.
  - Next sample pc=0x00000004 yields "00000004.\r\n" in full.
- With PC_UART_CHANGE_ONLY_EN: samples pc=0x10, 0x10, 0x14, each spaced past frame end.
  - Required: exactly 2 frames ("00000010." and "00000014."); dropped=0.
  - A repeat 0x10 with trap=1 sends a third frame, "00000010T".
